// File: rtl/hovalaag_host_seq.sv
// hovalaag_host_seq: host-side step sequencer for the Hovalaag wrapper bus.
// Each step loads the IN1/IN2 heads and the instruction at pc into the
// wrapper, fires execute, then reads back status, the new pc and any OUT word.
// Ports: clk, reset (sync, active-high), run;
//   prog_addr/prog_data : program ROM (data valid 1 cycle after address);
//   in1_*/in2_*         : input stream heads, in*_ready is a 1-cycle pop;
//   out1_*/out2_*       : output streams, valid held until ready;
//   bus_addr/bus_wdata/bus_rdata : 1-hot wrapper bus;
//   pc, step_done, underflow (sticky), busy.
// Build option: define HOVALAAG_HOST_DBG_EN to add the DBG0..DBG3 readback
// states and the dbg_a..dbg_d outputs (each step grows by 4 cycles).
module hovalaag_host_seq #(
    parameter int PC_W = 8,
    parameter int DW   = 12
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            run,
    output logic [PC_W-1:0] prog_addr,
    input  logic [31:0]     prog_data,
    input  logic [DW-1:0]   in1_data,
    input  logic            in1_valid,
    output logic            in1_ready,
    input  logic [DW-1:0]   in2_data,
    input  logic            in2_valid,
    output logic            in2_ready,
    output logic [DW-1:0]   out1_data,
    output logic            out1_valid,
    input  logic            out1_ready,
    output logic [DW-1:0]   out2_data,
    output logic            out2_valid,
    input  logic            out2_ready,
    output logic [9:0]      bus_addr,
    output logic [5:0]      bus_wdata,
    input  logic [7:0]      bus_rdata,
    output logic [PC_W-1:0] pc,
    output logic            step_done,
    output logic            underflow,
`ifdef HOVALAAG_HOST_DBG_EN
    output logic [7:0]      dbg_a,
    output logic [7:0]      dbg_b,
    output logic [7:0]      dbg_c,
    output logic [7:0]      dbg_d,
`endif
    output logic            busy
);

    localparam logic [4:0] S_IDLE   = 5'd0;
    localparam logic [4:0] S_LD_I1L = 5'd1;
    localparam logic [4:0] S_LD_I1H = 5'd2;
    localparam logic [4:0] S_LD_I2L = 5'd3;
    localparam logic [4:0] S_LD_I2H = 5'd4;
    localparam logic [4:0] S_I0     = 5'd5;
    localparam logic [4:0] S_I1     = 5'd6;
    localparam logic [4:0] S_I2     = 5'd7;
    localparam logic [4:0] S_I3     = 5'd8;
    localparam logic [4:0] S_I4     = 5'd9;
    localparam logic [4:0] S_EXEC   = 5'd10;
    localparam logic [4:0] S_RD_PC  = 5'd11;
`ifdef HOVALAAG_HOST_DBG_EN
    localparam logic [4:0] S_DBG0   = 5'd12;
    localparam logic [4:0] S_DBG1   = 5'd13;
    localparam logic [4:0] S_DBG2   = 5'd14;
    localparam logic [4:0] S_DBG3   = 5'd15;
`endif
    localparam logic [4:0] S_RD_OL  = 5'd16;
    localparam logic [4:0] S_RD_OH  = 5'd17;
    localparam logic [4:0] S_PUSH   = 5'd18;
    localparam logic [4:0] S_DONE   = 5'd19;

    logic [4:0]    state;
    logic [3:0]    status;
    logic [7:0]    lo;
    logic [DW-1:0] h1;
    logic [DW-1:0] h2;
    logic          has_out;
    logic [4:0]    after_pc;

    // An empty stream presents a zero head to the CPU.
    assign h1 = in1_valid ? in1_data : '0;
    assign h2 = in2_valid ? in2_data : '0;

    assign has_out  = status[2] | status[3];
`ifdef HOVALAAG_HOST_DBG_EN
    assign after_pc = S_DBG0;
`else
    assign after_pc = has_out ? S_RD_OL : S_DONE;
`endif

    assign prog_addr = pc;
    assign busy      = (state != S_IDLE);
    assign step_done = (state == S_DONE);
    assign in1_ready = (state == S_DONE) & status[0] & in1_valid;
    assign in2_ready = (state == S_DONE) & status[1] & in2_valid;

    // Read states rewrite an input register with its current head so the
    // wrapper's view of the inputs is unchanged by the readback.
    always_comb begin
        bus_addr  = '0;
        bus_wdata = '0;
        case (state)
            S_LD_I1L: begin bus_addr = 10'h040; bus_wdata = h1[5:0];  end
            S_LD_I1H: begin bus_addr = 10'h080; bus_wdata = h1[11:6]; end
            S_LD_I2L: begin bus_addr = 10'h100; bus_wdata = h2[5:0];  end
            S_LD_I2H: begin bus_addr = 10'h200; bus_wdata = h2[11:6]; end
            S_I0:     begin bus_addr = 10'h001; bus_wdata = prog_data[5:0];   end
            S_I1:     begin bus_addr = 10'h002; bus_wdata = prog_data[11:6];  end
            S_I2:     begin bus_addr = 10'h004; bus_wdata = prog_data[17:12]; end
            S_I3:     begin bus_addr = 10'h008; bus_wdata = prog_data[23:18]; end
            S_I4:     begin bus_addr = 10'h010; bus_wdata = prog_data[29:24]; end
            S_EXEC: begin
                bus_addr  = 10'h020;
                bus_wdata = {4'b0, prog_data[31:30]};
            end
            S_RD_PC:  begin bus_addr = 10'h040; bus_wdata = h1[5:0];  end
`ifdef HOVALAAG_HOST_DBG_EN
            S_DBG0:   begin bus_addr = 10'h001; bus_wdata = prog_data[5:0];   end
            S_DBG1:   begin bus_addr = 10'h002; bus_wdata = prog_data[11:6];  end
            S_DBG2:   begin bus_addr = 10'h004; bus_wdata = prog_data[17:12]; end
            S_DBG3:   begin bus_addr = 10'h008; bus_wdata = prog_data[23:18]; end
`endif
            S_RD_OL:  begin bus_addr = 10'h080; bus_wdata = h1[11:6]; end
            S_RD_OH:  begin bus_addr = 10'h100; bus_wdata = h2[5:0];  end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            pc         <= '0;
            status     <= '0;
            lo         <= '0;
            out1_data  <= '0;
            out1_valid <= 1'b0;
            out2_data  <= '0;
            out2_valid <= 1'b0;
            underflow  <= 1'b0;
`ifdef HOVALAAG_HOST_DBG_EN
            dbg_a      <= '0;
            dbg_b      <= '0;
            dbg_c      <= '0;
            dbg_d      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (run) state <= S_LD_I1L;
                end
                S_LD_I1L, S_LD_I1H, S_LD_I2L, S_LD_I2H,
                S_I0, S_I1, S_I2, S_I3, S_I4: begin
                    state <= state + 5'd1;
                end
                // This edge is also the CPU clock edge; status reflects
                // the step just executed.
                S_EXEC: begin
                    status <= bus_rdata[3:0];
                    state  <= S_RD_PC;
                end
                S_RD_PC: begin
                    pc    <= PC_W'(bus_rdata);
                    state <= after_pc;
                end
`ifdef HOVALAAG_HOST_DBG_EN
                S_DBG0: begin dbg_a <= bus_rdata; state <= S_DBG1; end
                S_DBG1: begin dbg_b <= bus_rdata; state <= S_DBG2; end
                S_DBG2: begin dbg_c <= bus_rdata; state <= S_DBG3; end
                S_DBG3: begin
                    dbg_d <= bus_rdata;
                    state <= has_out ? S_RD_OL : S_DONE;
                end
`endif
                S_RD_OL: begin
                    lo    <= bus_rdata;
                    state <= S_RD_OH;
                end
                // OUT1 wins if the CPU ever reports both outputs valid.
                S_RD_OH: begin
                    if (status[2]) begin
                        out1_valid <= 1'b1;
                        out1_data  <= {bus_rdata[3:0], lo};
                    end else begin
                        out2_valid <= 1'b1;
                        out2_data  <= {bus_rdata[3:0], lo};
                    end
                    state <= S_PUSH;
                end
                S_PUSH: begin
                    if (out1_valid && out1_ready) begin
                        out1_valid <= 1'b0;
                        state      <= S_DONE;
                    end else if (out2_valid && out2_ready) begin
                        out2_valid <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if ((status[0] && !in1_valid) ||
                        (status[1] && !in2_valid))
                        underflow <= 1'b1;
                    state <= run ? S_LD_I1L : S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hovalaag_host_seq.sv
// tb_hovalaag_host_seq: randomized self-checking bench for hovalaag_host_seq.
// A wrapper model answers bus reads; expected bus traces are built per step.
`timescale 1ns/1ps
module tb_hovalaag_host_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        run;
    logic [7:0]  prog_addr;
    logic [31:0] prog_data;
    logic [11:0] in1_data;
    logic        in1_valid;
    logic        in1_ready;
    logic [11:0] in2_data;
    logic        in2_valid;
    logic        in2_ready;
    logic [11:0] out1_data;
    logic        out1_valid;
    logic        out1_ready;
    logic [11:0] out2_data;
    logic        out2_valid;
    logic        out2_ready;
    logic [9:0]  bus_addr;
    logic [5:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  pc;
    logic        step_done;
    logic        underflow;
    logic        busy;

    hovalaag_host_seq dut (
        .clk(clk), .reset(reset), .run(run),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .in1_data(in1_data), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .in2_data(in2_data), .in2_valid(in2_valid), .in2_ready(in2_ready),
        .out1_data(out1_data), .out1_valid(out1_valid),
        .out1_ready(out1_ready),
        .out2_data(out2_data), .out2_valid(out2_valid),
        .out2_ready(out2_ready),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .pc(pc), .step_done(step_done), .underflow(underflow), .busy(busy)
    );

    always #5 clk = ~clk;

    logic [31:0] rom [256];
    always @(posedge clk) prog_data <= rom[prog_addr];

    logic [7:0] w_status, w_pc, w_lo, w_hi;
    always_comb begin
        bus_rdata = 8'h00;
        case (bus_addr)
            10'h020: bus_rdata = w_status;
            10'h040: bus_rdata = w_pc;
            10'h080: bus_rdata = w_lo;
            10'h100: bus_rdata = w_hi;
            default: ;
        endcase
    end

    int vectors = 0;
    int miscompares = 0;
    logic [7:0]  m_pc;
    logic        m_uf;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];
    int          last_v1n;
    logic [11:0] last_o1;

    task automatic run_step(input string name, input logic [31:0] instr,
                            input logic [11:0] d1, input logic v1,
                            input logic [11:0] d2, input logic v2,
                            input logic [7:0] st, input logic [7:0] npc,
                            input logic [7:0] lo, input logic [7:0] hi,
                            input int stall);
        logic [11:0] h1, h2, o1, o2, want_data;
        int n, r1n, r2n, v1n, v2n, bad, exp_v1, exp_v2;
        logic r1d, r2d, done, want1, want2, exp_r1, exp_r2;
        rom[m_pc] = instr;
        in1_data = d1; in1_valid = v1;
        in2_data = d2; in2_valid = v2;
        w_status = st; w_pc = npc; w_lo = lo; w_hi = hi;
        out1_ready = 1'b0; out2_ready = 1'b0;
        h1 = v1 ? d1 : 12'h0;
        h2 = v2 ? d2 : 12'h0;
        want1 = st[2];
        want2 = !st[2] && st[3];
        exp_v1 = want1 ? stall + 1 : 0;
        exp_v2 = want2 ? stall + 1 : 0;
        exp_r1 = st[0] & v1;
        exp_r2 = st[1] & v2;
        want_data = {hi[3:0], lo};
        exp_q.delete();
        exp_q.push_back({10'h040, h1[5:0]});
        exp_q.push_back({10'h080, h1[11:6]});
        exp_q.push_back({10'h100, h2[5:0]});
        exp_q.push_back({10'h200, h2[11:6]});
        for (int k = 0; k < 5; k++)
            exp_q.push_back({10'(1 << k), 6'((instr >> (6 * k)) & 32'h3f)});
        exp_q.push_back({10'h020, 4'h0, instr[31:30]});
        exp_q.push_back({10'h040, h1[5:0]});
        if (st[2] | st[3]) begin
            exp_q.push_back({10'h080, h1[11:6]});
            exp_q.push_back({10'h100, h2[5:0]});
            for (int k = 0; k <= stall; k++) exp_q.push_back(16'h0);
        end
        exp_q.push_back(16'h0);

        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        obs_q.delete();
        n = 0; done = 0; r1n = 0; r2n = 0; v1n = 0; v2n = 0;
        r1d = 0; r2d = 0; o1 = 0; o2 = 0;
        while (!done && n < 64) begin
            n++;
            obs_q.push_back({bus_addr, bus_wdata});
            if (in1_ready) r1n++;
            if (in2_ready) r2n++;
            if (out1_valid) begin v1n++; o1 = out1_data; end
            if (out2_valid) begin v2n++; o2 = out2_data; end
            if (step_done) begin done = 1; r1d = in1_ready; r2d = in2_ready; end
            out1_ready = want1 && out1_valid && (v1n == stall + 1);
            out2_ready = want2 && out2_valid && (v2n == stall + 1);
            @(negedge clk);
        end
        out1_ready = 1'b0; out2_ready = 1'b0;
        last_v1n = v1n; last_o1 = o1;

        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL %s step_done: none in %0d cycles, want one", name, n);
        end
        bad = -1;
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            if (bad < 0 && obs_q[i] !== exp_q[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL %s trace[%0d]: got %h want %h",
                     name, bad, obs_q[bad], exp_q[bad]);
        end else if (obs_q.size() != exp_q.size()) begin
            miscompares++;
            $display("FAIL %s length: got %0d want %0d",
                     name, obs_q.size(), exp_q.size());
        end
        vectors++;
        if (pc !== npc || prog_addr !== npc) begin
            miscompares++;
            $display("FAIL %s pc: got %h/%h want %h", name, pc, prog_addr, npc);
        end
        vectors++;
        if (r1n != int'(exp_r1) || r1d !== exp_r1 ||
            r2n != int'(exp_r2) || r2d !== exp_r2) begin
            miscompares++;
            $display("FAIL %s ready: got %0d/%b %0d/%b want %0d %0d",
                     name, r1n, r1d, r2n, r2d, exp_r1, exp_r2);
        end
        vectors++;
        if (v1n != exp_v1 || (exp_v1 > 0 && o1 !== want_data)) begin
            miscompares++;
            $display("FAIL %s out1: got %0d cyc %h want %0d cyc %h",
                     name, v1n, o1, exp_v1, want_data);
        end
        vectors++;
        if (v2n != exp_v2 || (exp_v2 > 0 && o2 !== want_data)) begin
            miscompares++;
            $display("FAIL %s out2: got %0d cyc %h want %0d cyc %h",
                     name, v2n, o2, exp_v2, want_data);
        end
        m_uf = m_uf | (st[0] & !v1) | (st[1] & !v2);
        vectors++;
        if (underflow !== m_uf) begin
            miscompares++;
            $display("FAIL %s underflow: got %b want %b", name, underflow, m_uf);
        end
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s idle: busy got %b want 0", name, busy);
        end
        m_pc = npc;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus_addr, bus_wdata} !== 16'h0) begin
            miscompares++;
            $display("FAIL reset bus: got %h want 0", {bus_addr, bus_wdata});
        end
        reset = 1'b0;
        @(negedge clk);
        vectors++;
        if (pc !== 8'h0 || prog_addr !== 8'h0) begin
            miscompares++;
            $display("FAIL reset pc: got %h want 0", pc);
        end
        vectors++;
        if ({busy, step_done, underflow} !== 3'b0) begin
            miscompares++;
            $display("FAIL reset flags: got %b want 000",
                     {busy, step_done, underflow});
        end
        vectors++;
        if ({in1_ready, in2_ready, out1_valid, out2_valid} !== 4'b0) begin
            miscompares++;
            $display("FAIL reset handshake: got %b want 0000",
                     {in1_ready, in2_ready, out1_valid, out2_valid});
        end
        vectors++;
        if ({out1_data, out2_data} !== 24'h0) begin
            miscompares++;
            $display("FAIL reset outdata: got %h want 0", {out1_data, out2_data});
        end
        m_pc = 8'h0;
        m_uf = 1'b0;
    endtask

    task automatic test_basic();
        logic [9:0] ref_addr [12];
        int bad;
        ref_addr = '{10'h040, 10'h080, 10'h100, 10'h200, 10'h001, 10'h002,
                     10'h004, 10'h008, 10'h010, 10'h020, 10'h040, 10'h000};
        run_step("basic", 32'h0, 12'h0, 0, 12'h0, 0, 8'h00, 8'h01,
                 8'h00, 8'h00, 0);
        bad = (obs_q.size() == 12) ? -1 : 99;
        for (int i = 0; i < 12 && i < obs_q.size(); i++)
            if (bad < 0 && obs_q[i][15:6] !== ref_addr[i]) bad = i;
        vectors++;
        if (bad >= 0) begin
            miscompares++;
            $display("FAIL basic addr seq: got idx %0d size %0d want 12 steps",
                     bad, obs_q.size());
        end
    endtask

    task automatic test_instr();
        run_step("instr", 32'hC000_003F, 12'h0, 0, 12'h0, 0, 8'h00, 8'h02,
                 8'h00, 8'h00, 0);
        vectors++;
        if (obs_q.size() < 10) begin
            miscompares++;
            $display("FAIL instr chunks: got %0d cycles want 12", obs_q.size());
        end else if (obs_q[4][5:0] !== 6'h3F || obs_q[9][5:0] !== 6'h03) begin
            miscompares++;
            $display("FAIL instr chunks: got %h %h want 3f 03",
                     obs_q[4][5:0], obs_q[9][5:0]);
        end
    endtask

    task automatic test_in1_head();
        run_step("in1head", 32'h1234_5678, 12'hABC, 1, 12'h0, 0, 8'h00,
                 8'h03, 8'h00, 8'h00, 0);
        vectors++;
        if (obs_q.size() < 2 || obs_q[0][5:0] !== 6'h3C ||
            obs_q[1][5:0] !== 6'h2A) begin
            miscompares++;
            $display("FAIL in1head wdata: got %h %h want 3c 2a",
                     obs_q[0], obs_q[1]);
        end
    endtask

    task automatic test_output();
        run_step("output", 32'h0, 12'h123, 1, 12'h456, 1, 8'h05, 8'h04,
                 8'h34, 8'h0F, 3);
        vectors++;
        if (last_v1n != 4 || last_o1 !== 12'hF34) begin
            miscompares++;
            $display("FAIL output out1: got %0d cyc %h want 4 cyc f34",
                     last_v1n, last_o1);
        end
    endtask

    task automatic test_underflow();
        run_step("uflow", 32'h0, 12'h0, 0, 12'h0, 0, 8'h02, 8'h05,
                 8'h00, 8'h00, 0);
        run_step("uflow2", 32'h0, 12'h0, 0, 12'h0, 0, 8'h00, 8'h06,
                 8'h00, 8'h00, 0);
        vectors++;
        if (underflow !== 1'b1) begin
            miscompares++;
            $display("FAIL uflow sticky: got %b want 1", underflow);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            run_step("random", $urandom, 12'($urandom), 1'($urandom_range(0, 1)),
                     12'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom),
                     $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back();
        int n;
        logic all_busy;
        for (int i = 0; i < 256; i++) rom[i] = $urandom;
        in1_valid = 1'b0; in2_valid = 1'b0;
        w_status = 8'h00; w_pc = 8'h5A;
        @(negedge clk); run = 1'b1;
        n = 0;
        while (!step_done && n < 40) begin @(negedge clk); n++; end
        all_busy = 1'b1;
        for (int s = 0; s < 2; s++) begin
            n = 0;
            do begin
                @(negedge clk); n++;
                all_busy = all_busy & busy;
            end while (!step_done && n < 40);
            vectors++;
            if (n != 12) begin
                miscompares++;
                $display("FAIL b2b gap: got %0d want 12", n);
            end
        end
        vectors++;
        if (all_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b busy: got %b want 1", all_busy);
        end
        repeat (3) @(negedge clk);
        run = 1'b0;
        n = 0;
        while (!step_done && n < 40) begin @(negedge clk); n++; end
        vectors++;
        if (n != 9) begin
            miscompares++;
            $display("FAIL b2b stop: got %0d cycles want 9", n);
        end
        @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || pc !== 8'h5A) begin
            miscompares++;
            $display("FAIL b2b idle: got busy %b pc %h want 0 5a", busy, pc);
        end
        m_pc = 8'h5A;
    endtask

    task automatic test_reset_push();
        int n;
        in1_valid = 1'b0; in2_valid = 1'b0;
        w_status = 8'h04; w_pc = 8'h77; w_lo = 8'h11; w_hi = 8'h02;
        out1_ready = 1'b0; out2_ready = 1'b0;
        @(negedge clk); run = 1'b1;
        @(negedge clk); run = 1'b0;
        n = 0;
        while (!out1_valid && n < 40) begin @(negedge clk); n++; end
        vectors++;
        if (out1_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rstpush reach: got valid %b want 1", out1_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (out1_valid !== 1'b0 || bus_addr !== 10'h0 ||
            pc !== 8'h0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rstpush: got v%b a%h pc%h b%b want 0 0 0 0",
                     out1_valid, bus_addr, pc, busy);
        end
        reset = 1'b0;
        m_pc = 8'h0;
        m_uf = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 32'h0;
        reset = 1'b1; run = 1'b0;
        in1_data = 12'h0; in1_valid = 1'b0;
        in2_data = 12'h0; in2_valid = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        w_status = 8'h0; w_pc = 8'h0; w_lo = 8'h0; w_hi = 8'h0;
        m_pc = 8'h0; m_uf = 1'b0;
        last_v1n = 0; last_o1 = 12'h0;
        test_reset();
        test_basic();
        test_instr();
        test_in1_head();
        test_output();
        test_underflow();
        test_random();
        test_back_to_back();
        test_reset_push();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hovalaag_host_seq.md
Name: hovalaag_host_seq

Overview:
Host-side sequencer that drives the Hovalaag wrapper's 1-hot address / 6-bit write / 8-bit read bus.
- Per CPU step: loads IN1/IN2 stream heads, fetches the 32-bit instruction at the current PC from program memory, and shifts it in as six chunks.
- Fires execute, then reads back status, new PC and any OUT value.
- Turns the CPU's advance/valid flags into ready/valid stream handshakes.
- Sits between the program ROM and stream FIFOs on one side and the wrapper on the other.

Parameters:
PC_W, 8, program counter / prog_addr width
DW, 12, IN/OUT data width (fixed by CPU; do not change)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
run  in  1  level; when 1, steps execute back-to-back
prog_addr  out  PC_W  program memory address (= pc register)
prog_data  in  32  instruction; valid 1 cycle after prog_addr changes
in1_data  in  12  IN1 stream head
in1_valid  in  1  IN1 head valid
in1_ready  out  1  1-cycle pop pulse
in2_data, in2_valid, in2_ready  same as IN1
out1_data  out  12  OUT1 value
out1_valid  out  1  held until out1_ready
out1_ready  in  1  consumer accept
out2_data, out2_valid, out2_ready  same as OUT1
bus_addr  out  10  1-hot wrapper address
bus_wdata  out  6  wrapper write data
bus_rdata  in  8  wrapper read data
pc  out  PC_W  current PC
step_done  out  1  1-cycle pulse at end of each step
underflow  out  1  sticky; CPU advanced an empty input
busy  out  1  1 when not IDLE

Behaviour:
- Reset: state=IDLE, pc=0, bus_addr=0, bus_wdata=0, all ready/valid outputs 0, out data 0, underflow=0, step_done=0. Reset mid-step aborts immediately, with no pop and no push. The wrapper shares the same reset.
- IDLE: bus_addr=0. When run=1, go to LD_I1L on the next edge.
- Input load:
  - LD_I1L: bus_addr bit6, wdata=in1 head[5:0].
  - LD_I1H: bit7, [11:6].
  - LD_I2L: bit8, in2 head[5:0].
  - LD_I2H: bit9, in2 head[11:6].
  - Head is 0 if valid=0.
- Instruction load: I0..I4 drive bit0..bit4 with prog_data[5:0], [11:6], [17:12], [23:18], [29:24]. prog_data is valid by I0 because pc is stable ≥4 cycles earlier.
- EXEC:
  - Drive bit5, wdata={4'b0, prog_data[31:30]}.
  - Capture bus_rdata[3:0] into the status register at the end of the cycle, which is also the CPU clock edge:
    - s0 = in1_adv
    - s1 = in2_adv
    - s2 = out1_valid
    - s3 = out2_valid
- RD_PC: bit6 with wdata=in1 head[5:0] (rewrite is harmless); capture pc ← bus_rdata.
- Output read, only if s2|s3:
  - RD_OL: bit7, with wdata = in1 head[11:6]; capture lo = rdata[7:0].
  - RD_OH: bit8, with wdata = in2 head[5:0]; capture hi = rdata[3:0].
  - PUSH: bus_addr=0. Assert out1_valid (s2) or out2_valid (s3) with data {hi,lo}. Stay in PUSH until the matching ready is sampled 1.
  - s2&s3 both set is impossible from the CPU; if seen, OUT1 takes priority.
- DONE:
  - bus_addr=0; pulse step_done.
  - in1_ready=s0&in1_valid and in2_ready=s1&in2_valid, for exactly this cycle.
  - If s0&!in1_valid or s1&!in2_valid, set underflow.
  - Next state: LD_I1L if run, else IDLE.
- Step length: 12 cycles without output; 15 cycles minimum with output, plus any ready stall cycles.
- run deasserted mid-step: the step completes, then IDLE.
- pc wraps naturally; the new value comes only from the CPU, never incremented locally.
- Exactly one bus_addr bit is set in every non-IDLE/PUSH/DONE state.

Optional Feature:
HOVALAAG_HOST_DBG_EN:
- Defined:
  - Adds outputs dbg_a, dbg_b, dbg_c, dbg_d (8 bits each).
  - Adds states DBG0..DBG3 between RD_PC and output read. These drive bus_addr bit0..3 with wdata equal to the matching prog_data chunk, so the instr is unchanged.
  - Capture bus_rdata into dbg_a..dbg_d.
  - All step lengths grow by 4 cycles.
  - dbg_* reset to 0.
- Undefined: no DBG states and no dbg ports.

Test Plan:
- Reset then run=1, prog_data=32'h0000_0000, wrapper model returns PC=1 and status=0 → bus_addr sequence 040,080,100,200,001,002,004,008,010,020,040,0 (hex). step_done at cycle 12, pc=1, no ready pulses.
- prog_data=32'hC000_003F → I0 wdata=6'h3F, EXEC wdata=6'h03.
- in1_data=12'hABC, in1_valid=1 → LD_I1L wdata=6'h3C, LD_I1H wdata=6'h2A.
- Status=4'b0101, in1_valid=1, rdata at RD_OL=8'h34, at RD_OH=8'h0F, out1_ready held 0 for 3 cycles → out1_valid with out1_data=12'hF34 held 4 cycles. in1_ready pulses once in DONE.
- Status s1=1 with in2_valid=0 → underflow=1 and stays 1 for later steps; in2_ready stays 0.
- Assert reset during PUSH → next cycle out1_valid=0, bus_addr=0, pc=0, busy=0.
